lsu_align: RTL and testbench
============================

# lsu_align

Load/store alignment unit between the core's memory stage and the variable-access data memory (byte/half/word modes, combinational read, write on rising edge). It accepts one RISC-V load or store per handshake and splits misaligned halfword/word accesses into a sequence of naturally aligned beats. For loads it assembles and sign/zero-extends the result, then returns a one-cycle response. Stores get the same response, used as a completion acknowledge.

## Interface
- No parameters; address and data are fixed at 32 bits.
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted on an edge with valid&ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal funct3; valid with resp_valid
- mem_accessmode  out  2  00 byte, 01 half, 10 word
- mem_we  out  1  memory write enable
- mem_a  out  32  beat address
- mem_wd  out  32  beat write data, right-aligned
- mem_rd  in  32  memory read data, right-aligned and masked to the access size

## Operation
- FSM states: IDLE, BEAT, DONE.
  - IDLE: on accept, latch we/funct3/addr/wdata and compute beat count n. Legal requests go to BEAT with beat index 0. Illegal requests go to DONE with err=1.
  - BEAT: issue beat k. If k = n-1, go to DONE; otherwise increment k.
  - DONE: resp_valid=1 for one cycle, then go to IDLE.
- Illegal funct3: loads 011, 110, 111; stores anything other than 000/001/010. These issue no memory beats.
- Beat plan (A = latched address; address arithmetic wraps mod 2^32):
  - Byte, any A: 1 beat, mode 00 at A, data bits [7:0].
  - Half, A[0]=0: 1 beat, mode 01 at A, bits [15:0].
  - Half, A[0]=1: 2 beats, mode 00 at A for [7:0], then mode 00 at A+1 for [15:8].
  - Word, A[1:0]=00: 1 beat, mode 10 at A.
  - Word, A[1:0]=10: 2 beats, mode 01 at A for [15:0], then mode 01 at A+2 for [31:16].
  - Word, A[0]=1: 3 beats: mode 00 at A for [7:0], mode 01 at A+1 for [23:8], mode 00 at A+3 for [31:24].
- Stores: mem_wd carries the beat's slice of wdata, right-aligned, upper bits 0. mem_we=1 only during BEAT.
- Loads: at each BEAT edge, the low bits of mem_rd (8/16/32 per mode) are written into the matching slice of an assembly register.
- Load extension, registered into resp_rdata on entry to DONE:
  - LB: sign-extend bit 7.
  - LBU: zero-extend from 8 bits.
  - LH: sign-extend bit 15.
  - LHU: zero-extend from 16 bits.
  - LW: unchanged.
- Outside BEAT, the memory port idles at mem_we=0, mem_a=0, mem_wd=0, mem_accessmode=10.
- Reset (any state): state goes to IDLE immediately; all registers clear. Beats not yet issued are never issued. Store beats already written are not rolled back. No response is produced for the aborted request.

## Timing
- Reset values: req_ready=1 (IDLE), resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_a=0, mem_wd=0, mem_accessmode=10.
- Take the accept edge as the end of cycle 0. Beat k is driven in cycle k+1. resp_valid is high in cycle n+1. req_ready is high again in cycle n+2.
- Aligned access: 3 cycles per request. Worst case (word, A[0]=1): 5 cycles.
- Illegal request: resp_valid with resp_err=1 in cycle 1.
- req_ready=0 in BEAT and DONE; req_valid is ignored there.
- resp_rdata and resp_err are held until the next response.

## Test plan
- Preload memory: word@0x0=0x44332211, word@0x4=0x88776655. LW at 0x1 -> beats (00,0x1), (01,0x2), (00,0x4); resp_rdata=0x55443322 in cycle 4.
- LH at 0x3 -> 2 byte beats; resp_rdata=0x00005544. LB at 0x7 -> 0xFFFFFF88. LBU at 0x7 -> 0x00000088. LW at 0x4 -> 1 beat, 0x88776655, resp_valid in cycle 2.
- SW 0xAABBCCDD at 0x2 -> 2 half beats with mem_wd 0xCCDD then 0xAABB; memory becomes word0=0xCCDD2211, word1=0x8877AABB.
- Load with funct3=011 -> no mem_we and no beats; resp_valid with resp_err=1, resp_rdata=0 in cycle 1. The following legal LW is accepted normally.
- Assert reset during beat 1 of a 3-beat SW -> only beat 0 is written; outputs return to reset values immediately; no resp_valid; req_ready=1 after release.
- Back-to-back: hold req_valid=1 throughout -> each request is accepted exactly once; req_ready stays low through BEAT and DONE; responses arrive in order.

Source files
------------

// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between the memory stage and a
// byte/half/word data memory with combinational read and rising-edge write.
// One request is accepted per handshake. A misaligned halfword or word is
// split into naturally aligned beats. A load's result is assembled,
// extended and returned with a one-cycle response. A store returns the same
// response as a completion acknowledge.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   req_valid / req_ready      request handshake; ready only while idle
//   req_we                     1 = store, 0 = load
//   req_funct3                 RISC-V width/sign encoding
//   req_addr, req_wdata        byte address, right-aligned store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata                 extended load data (0 for stores/errors)
//   resp_err                   illegal funct3 flag, qualified by resp_valid
//   mem_accessmode             00 byte, 01 half, 10 word
//   mem_we, mem_a, mem_wd      beat write enable, address, right-aligned data
//   mem_rd                     right-aligned, size-masked read data
module lsu_align (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [1:0]  mem_accessmode,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [1:0] {
      IDLE,
      BEAT,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nx;

   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  last_q;
   logic [1:0]  k_q;
   logic [31:0] asm_q;

   logic [1:0]  beat_mode;
   logic [1:0]  beat_off;
   logic [4:0]  beat_sh;
   logic [31:0] beat_mask;
   logic [31:0] beat_addr;
   logic [31:0] beat_wd;
   logic [31:0] asm_nx;
   logic        req_legal;
   logic        last_beat_now;

   function automatic logic legal_op(input logic we, input logic [2:0] f3);
      if (we)
         return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      else
         return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
   endfunction

   // Index of the final beat for a given access size and address offset.
   function automatic logic [1:0] last_index(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'b00:   return 2'd0;
         2'b01:   return a[0] ? 2'd1 : 2'd0;
         default: begin
            if (a == 2'b00)      return 2'd0;
            else if (a == 2'b10) return 2'd1;
            else                 return 2'd2;
         end
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
      case (f3)
         3'b000:  return {{24{v[7]}}, v[7:0]};
         3'b100:  return {24'h0, v[7:0]};
         3'b001:  return {{16{v[15]}}, v[15:0]};
         3'b101:  return {16'h0, v[15:0]};
         default: return v;
      endcase
   endfunction

   assign req_legal     = legal_op(req_we, req_funct3);
   assign last_beat_now = (k_q == last_q);

   // Beat plan: mode, byte offset from the latched address, and bit position
   // of the beat's slice within the full datum.
   always_comb begin
      beat_mode = 2'b10;
      beat_off  = 2'd0;
      beat_sh   = 5'd0;
      case (f3_q[1:0])
         2'b00: beat_mode = 2'b00;
         2'b01: begin
            if (addr_q[0]) begin
               beat_mode = 2'b00;
               if (k_q[0]) begin
                  beat_off = 2'd1;
                  beat_sh  = 5'd8;
               end
            end else begin
               beat_mode = 2'b01;
            end
         end
         default: begin
            case (addr_q[1:0])
               2'b00: beat_mode = 2'b10;
               2'b10: begin
                  beat_mode = 2'b01;
                  if (k_q[0]) begin
                     beat_off = 2'd2;
                     beat_sh  = 5'd16;
                  end
               end
               default: begin
                  case (k_q)
                     2'd0: beat_mode = 2'b00;
                     2'd1: begin
                        beat_mode = 2'b01;
                        beat_off  = 2'd1;
                        beat_sh   = 5'd8;
                     end
                     default: begin
                        beat_mode = 2'b00;
                        beat_off  = 2'd3;
                        beat_sh   = 5'd24;
                     end
                  endcase
               end
            endcase
         end
      endcase
   end

   always_comb begin
      case (beat_mode)
         2'b00:   beat_mask = 32'h0000_00FF;
         2'b01:   beat_mask = 32'h0000_FFFF;
         default: beat_mask = '1;
      endcase
   end

   assign beat_addr = addr_q + {30'h0, beat_off};
   assign beat_wd   = (wdata_q >> beat_sh) & beat_mask;
   // Merge the current beat's read data into its slice of the assembly value;
   // the last beat's merge feeds extension directly so the response can be
   // registered on the same edge.
   assign asm_nx    = (asm_q & ~(beat_mask << beat_sh)) | ((mem_rd & beat_mask) << beat_sh);

   always_comb begin
      req_ready      = (state == IDLE);
      resp_valid     = (state == DONE);
      mem_we         = 1'b0;
      mem_a          = '0;
      mem_wd         = '0;
      mem_accessmode = 2'b10;
      if (state == BEAT) begin
         mem_we         = we_q;
         mem_a          = beat_addr;
         mem_wd         = we_q ? beat_wd : '0;
         mem_accessmode = beat_mode;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (req_valid)
               state_nx = req_legal ? BEAT : DONE;
         end
         BEAT: begin
            if (last_beat_now)
               state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q       <= 1'b0;
         f3_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         last_q     <= '0;
         k_q        <= '0;
         asm_q      <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  last_q  <= last_index(req_funct3[1:0], req_addr[1:0]);
                  k_q     <= '0;
                  asm_q   <= '0;
                  if (!req_legal) begin
                     resp_rdata <= '0;
                     resp_err   <= 1'b1;
                  end
               end
            end
            BEAT: begin
               if (!we_q)
                  asm_q <= asm_nx;
               if (last_beat_now) begin
                  resp_rdata <= we_q ? '0 : extend(asm_nx, f3_q);
                  resp_err   <= 1'b0;
               end else begin
                  k_q <= k_q + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_align.sv
// Testbench for lsu_align: byte-array memory on the DUT port, reference
// model of the same memory, and a response scoreboard checked by a monitor.
module tb_lsu_align;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [1:0]  mem_accessmode;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   always #5 clk = ~clk;

   lsu_align dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_accessmode (mem_accessmode),
      .mem_we         (mem_we),
      .mem_a          (mem_a),
      .mem_wd         (mem_wd),
      .mem_rd         (mem_rd)
   );

   // Memory seen by the DUT (256 bytes, address wraps on the low 8 bits).
   logic [7:0] dmem [256];
   // Reference copy updated by the model.
   logic [7:0] rmem [256];

   always_comb begin
      logic [7:0] a0;
      a0 = mem_a[7:0];
      case (mem_accessmode)
         2'b00:   mem_rd = {24'h0, dmem[a0]};
         2'b01:   mem_rd = {16'h0, dmem[8'(a0 + 8'd1)], dmem[a0]};
         default: mem_rd = {dmem[8'(a0 + 8'd3)], dmem[8'(a0 + 8'd2)],
                            dmem[8'(a0 + 8'd1)], dmem[a0]};
      endcase
   end

   always @(posedge clk) begin
      if (mem_we) begin
         case (mem_accessmode)
            2'b00: dmem[mem_a[7:0]] <= mem_wd[7:0];
            2'b01: begin
               dmem[mem_a[7:0]]               <= mem_wd[7:0];
               dmem[8'(mem_a[7:0] + 8'd1)]    <= mem_wd[15:8];
            end
            default: begin
               dmem[mem_a[7:0]]               <= mem_wd[7:0];
               dmem[8'(mem_a[7:0] + 8'd1)]    <= mem_wd[15:8];
               dmem[8'(mem_a[7:0] + 8'd2)]    <= mem_wd[23:16];
               dmem[8'(mem_a[7:0] + 8'd3)]    <= mem_wd[31:24];
            end
         endcase
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   logic manual = 1'b0;

   typedef struct {
      logic        we;
      logic        err;
      logic [31:0] rdata;
      int          n;
      int          acc;
   } exp_t;

   exp_t sbq[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic ref_legal(input logic we, input logic [2:0] f3);
      if (we) return f3 inside {3'd0, 3'd1, 3'd2};
      return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
   endfunction

   function automatic int ref_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   // Greedy split into the largest naturally aligned pieces.
   function automatic int ref_beats(input logic [2:0] f3, input logic [31:0] addr);
      int r;
      int n;
      logic [31:0] a;
      r = ref_size(f3);
      a = addr;
      n = 0;
      while (r > 0) begin
         int p;
         if (r >= 4 && a[1:0] == 2'b00)  p = 4;
         else if (r >= 2 && a[0] == 1'b0) p = 2;
         else                            p = 1;
         a = a + 32'(p);
         r = r - p;
         n++;
      end
      return n;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
      logic [31:0] v;
      logic [31:0] t;
      int sz;
      sz = ref_size(f3);
      v  = '0;
      for (int i = 0; i < sz; i++) begin
         t = addr + 32'(i);
         v = v | (32'(rmem[t[7:0]]) << (8 * i));
      end
      if (!f3[2] && sz < 4 && v[8 * sz - 1])
         v = v | ~((32'h1 << (8 * sz)) - 32'h1);
      return v;
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] t;
      for (int i = 0; i < ref_size(f3); i++) begin
         t = addr + 32'(i);
         rmem[t[7:0]] = wd[8 * i +: 8];
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!reset) begin
         if (sbq.size() > 0)
            chk("ready_while_busy", {31'h0, req_ready}, 32'h0);
         if (mem_we && !manual) begin
            checks++;
            if (!(sbq.size() > 0 && sbq[0].we && !sbq[0].err)) begin
               errors++;
               $display("FAIL spurious_mem_we got 1 exp 0 (t=%0t)", $time);
            end
         end
         if (resp_valid) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp got resp_valid=1 exp 0 (t=%0t)", $time);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("resp_rdata", resp_rdata, e.rdata);
               chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
               chk("resp_latency", 32'(cyc - e.acc), 32'(e.n));
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic track,
                        input logic use_exp, input logic [31:0] exp_rd);
      exp_t e;
      int   w;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      w = 0;
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout got req_ready=0 exp 1 (t=%0t)", $time);
         req_valid = 1'b0;
         return;
      end
      e.we    = we;
      e.err   = !ref_legal(we, f3);
      e.n     = e.err ? 0 : ref_beats(f3, addr);
      e.rdata = (e.err || we) ? 32'h0 : (use_exp ? exp_rd : ref_load(f3, addr));
      if (track && we && !e.err)
         ref_store(f3, addr, wd);
      @(posedge clk);
      #1;
      e.acc = cyc;
      if (track)
         sbq.push_back(e);
   endtask

   task automatic check_beat(input logic [1:0] mode, input logic [31:0] a,
                             input logic [31:0] wd, input logic we);
      chk("beat_mode", {30'h0, mem_accessmode}, {30'h0, mode});
      chk("beat_addr", mem_a, a);
      chk("beat_wd", mem_wd, wd);
      chk("beat_we", {31'h0, mem_we}, {31'h0, we});
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sbq.size() > 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (sbq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout got %0d pending exp 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
      chk({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
      chk({tag, "_resp_err"}, {31'h0, resp_err}, 32'h0);
      chk({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
      chk({tag, "_mem_a"}, mem_a, 32'h0);
      chk({tag, "_mem_wd"}, mem_wd, 32'h0);
      chk({tag, "_mem_mode"}, {30'h0, mem_accessmode}, 32'h2);
   endtask

   initial begin
      logic [7:0] b;
      logic [31:0] pre0;
      logic [31:0] pre1;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = '0;
      req_addr   = '0;
      req_wdata  = '0;
      pre0 = 32'h4433_2211;
      pre1 = 32'h8877_6655;
      for (int i = 0; i < 256; i++) begin
         if (i < 4)      b = pre0[8 * i +: 8];
         else if (i < 8) b = pre1[8 * (i - 4) +: 8];
         else            b = 8'($urandom);
         dmem[i] <= b;
         rmem[i]  = b;
      end
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;

      // Misaligned word: three beats.
      issue(1'b0, 3'b010, 32'h1, 32'h0, 1'b1, 1'b1, 32'h5544_3322);
      req_valid = 1'b0;
      check_beat(2'b00, 32'h1, 32'h0, 1'b0);
      check_beat(2'b01, 32'h2, 32'h0, 1'b0);
      check_beat(2'b00, 32'h4, 32'h0, 1'b0);
      issue(1'b0, 3'b001, 32'h3, 32'h0, 1'b1, 1'b1, 32'h0000_5544);
      issue(1'b0, 3'b000, 32'h7, 32'h0, 1'b1, 1'b1, 32'hFFFF_FF88);
      issue(1'b0, 3'b100, 32'h7, 32'h0, 1'b1, 1'b1, 32'h0000_0088);
      issue(1'b0, 3'b010, 32'h4, 32'h0, 1'b1, 1'b1, 32'h8877_6655);
      req_valid = 1'b0;
      drain();

      // Half-aligned word store.
      issue(1'b1, 3'b010, 32'h2, 32'hAABB_CCDD, 1'b1, 1'b0, 32'h0);
      req_valid = 1'b0;
      check_beat(2'b01, 32'h2, 32'h0000_CCDD, 1'b1);
      check_beat(2'b01, 32'h4, 32'h0000_AABB, 1'b1);
      drain();
      chk("sw_word0", {dmem[3], dmem[2], dmem[1], dmem[0]}, 32'hCCDD_2211);
      chk("sw_word1", {dmem[7], dmem[6], dmem[5], dmem[4]}, 32'h8877_AABB);

      // Illegal load, then a normal load.
      issue(1'b0, 3'b011, 32'h8, 32'h0, 1'b1, 1'b0, 32'h0);
      issue(1'b0, 3'b010, 32'h4, 32'h0, 1'b1, 1'b1, 32'h8877_AABB);
      req_valid = 1'b0;
      drain();

      // Reset during beat 1 of a 3-beat store: only beat 0 lands.
      manual = 1'b1;
      issue(1'b1, 3'b010, 32'h11, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      rmem[8'h11] = 8'hEF;
      #1;
      check_reset_outputs("abort");
      @(negedge clk);
      @(negedge clk);
      reset  = 1'b0;
      manual = 1'b0;
      @(negedge clk);
      chk("abort_ready_after", {31'h0, req_ready}, 32'h1);
      chk("abort_no_resp", {31'h0, resp_valid}, 32'h0);

      // Randomized traffic, valid mostly held high back-to-back.
      for (int i = 0; i < 200; i++) begin
         logic        we;
         logic [2:0]  f3;
         logic [31:0] addr;
         we = 1'($urandom);
         f3 = 3'($urandom);
         if ($urandom_range(0, 5) == 0)
            addr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
         else
            addr = 32'($urandom_range(0, 255));
         issue(we, f3, addr, $urandom, 1'b1, 1'b0, 32'h0);
         if ($urandom_range(0, 3) == 0) begin
            req_valid = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
         end
      end
      req_valid = 1'b0;
      drain();

      for (int i = 0; i < 256; i++)
         chk("final_mem", {24'h0, dmem[i]}, {24'h0, rmem[i]});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1);
   end

endmodule
